core_pipe_decode_issue: RTL and testbench
=========================================

CORE_PIPE_DECODE_ISSUE -- requirements
Module: core_pipe_decode_issue

Interface
REQ-001 SHALL have parameter PC_RESET_ADDRESS, default 'h10000000, the PC value after reset.
REQ-002 SHALL have port g_clk  in  1  global clock; one clock only, all state updates on its rising edge.
REQ-003 SHALL have port g_reset  in  1  global reset, synchronous and active-high.
REQ-004 SHALL have port cf_valid  in  1  control flow change requested.
REQ-005 SHALL have port cf_ack  in  1  control flow change accepted by fetch.
REQ-006 SHALL have port cf_target  in  64  control flow destination address.
REQ-007 SHALL have port s1_i16bit  in  1  a 16-bit instruction is present in the fetch buffer.
REQ-008 SHALL have port s1_i32bit  in  1  a 32-bit instruction is present in the fetch buffer.
REQ-009 SHALL have port s1_instr  in  32  fetch buffer head bytes, instruction in [15:0] or [31:0].
REQ-010 SHALL have port s1_ferr  in  2  per-halfword fetch error tag, bit0 = [15:0], bit1 = [31:16].
REQ-011 SHALL have port s1_eat_2  out  1  consume 2 bytes from fetch this cycle.
REQ-012 SHALL have port s1_eat_4  out  1  consume 4 bytes from fetch this cycle.
REQ-013 SHALL have port s2_valid  out  1  s2 holds a valid instruction.
REQ-014 SHALL have port s2_ready  in  1  downstream accepts s2 contents this cycle.
REQ-015 SHALL have port s2_pc  out  64  address of the s2 instruction.
REQ-016 SHALL have port s2_npc  out  64  sequential successor address, s2_pc + 2 or + 4.
REQ-017 SHALL have port s2_instr  out  32  instruction; upper 16 bits zero for 16-bit instructions.
REQ-018 SHALL have port s2_i32  out  1  1 = 32-bit instruction, 0 = 16-bit.
REQ-019 SHALL have port s2_ferr  out  1  instruction carries a fetch bus error.

Function
REQ-020 SHALL define e_cf = cf_valid && cf_ack.
REQ-021 SHALL define the slot as free when !s2_valid || s2_ready.
REQ-022 SHALL define accept = (s1_i16bit || s1_i32bit) && slot free && !e_cf && state == RUN.
REQ-023 SHALL drive s1_eat_2 = accept && s1_i16bit and s1_eat_4 = accept && s1_i32bit, combinationally, and never both at once.
REQ-024 SHALL hold a 64-bit fetch PC; on accept it advances by 2 (16-bit) or 4 (32-bit), wrapping modulo 2^64.
REQ-025 SHALL on e_cf load the fetch PC with {cf_target[63:1], 1'b0}; bit 0 of cf_target is ignored.
REQ-026 SHALL on accept load s2 registers the next cycle, 1-cycle latency: s2_valid=1, s2_pc=PC, s2_npc=PC+size, s2_instr, s2_i32, s2_ferr.
REQ-027 SHALL compute s2_ferr = s1_ferr[0] || (s1_i32bit && s1_ferr[1]).
REQ-028 SHALL clear s2_valid when s2_ready is high and accept is low.
REQ-029 SHALL hold all s2 outputs stable while s2_valid && !s2_ready && !e_cf.
REQ-030 SHALL clear s2_valid on e_cf regardless of s2_ready; flush has priority over accept and over stall.
REQ-031 SHALL implement two states, RUN and HALT; reset state is RUN.
REQ-032 SHALL transition RUN->HALT when an instruction with s2_ferr=1 is accepted; no further accepts occur in HALT.
REQ-033 SHALL transition HALT->RUN only on e_cf, which also performs the REQ-025 PC load.
REQ-034 SHALL ignore cf_valid without cf_ack: no PC change, no flush, and accept proceeds normally.
REQ-035 SHALL, with s1_i16bit and s1_i32bit both low, assert no eat and leave the PC unchanged.

Reset
REQ-036 SHALL, while g_reset=1, set PC=PC_RESET_ADDRESS, state=RUN, s2_valid=0, s2_pc=0, s2_npc=0, s2_instr=0, s2_i32=0, s2_ferr=0.
REQ-037 SHALL hold s1_eat_2=s1_eat_4=0 during any cycle with g_reset=1.
REQ-038 SHALL have reset asserted mid-operation override accept, e_cf and HALT, giving the REQ-036 state on the next edge.

Verification
REQ-039 SHALL test: after reset, s1_i32bit=1, s1_instr=0x00000013, s2_ready=1 -> s1_eat_4=1 same cycle; next cycle s2_valid=1, s2_pc=0x10000000, s2_npc=0x10000004, s2_i32=1.
REQ-040 SHALL test: 16-bit 0x4501 then 32-bit 0x00A00093 back-to-back -> s2_pc 0x10000000 then 0x10000002, s2_npc 0x10000002 then 0x10000006, s2_instr 0x00004501 then 0x00A00093.
REQ-041 SHALL test: s2_valid=1, s2_ready=0 for 3 cycles with the next instruction available -> no eats, s2 outputs unchanged; s2_ready=1 -> the next instruction issues on the following cycle.
REQ-042 SHALL test: cf_valid=cf_ack=1, cf_target=0x80000003, while s2 is stalled and an instruction is available -> no eat, s2_valid=0 next cycle; the next issue has s2_pc=0x80000002.
REQ-043 SHALL test: 32-bit instruction with s1_ferr=2'b10 -> s2_ferr=1 and HALT entered; eats stay 0 with instructions available until e_cf with cf_target=0x200 -> next s2_pc=0x200.
REQ-044 SHALL test: PC=0xFFFFFFFFFFFFFFFE with a 32-bit accept -> s2_npc=0x0000000000000002; g_reset pulsed mid-stall -> REQ-036 values.

Source files
------------

// File: rtl/core_pipe_decode_issue.sv
// Decode/issue stage: pulls 16- or 32-bit instructions from the fetch buffer,
// tracks the fetch PC and presents one instruction at a time in the s2 register.
module core_pipe_decode_issue #(
  parameter logic [63:0] PC_RESET_ADDRESS = 64'h10000000
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cf_valid,
  input  logic        cf_ack,
  input  logic [63:0] cf_target,
  input  logic        s1_i16bit,
  input  logic        s1_i32bit,
  input  logic [31:0] s1_instr,
  input  logic [1:0]  s1_ferr,
  output logic        s1_eat_2,
  output logic        s1_eat_4,
  output logic        s2_valid,
  input  logic        s2_ready,
  output logic [63:0] s2_pc,
  output logic [63:0] s2_npc,
  output logic [31:0] s2_instr,
  output logic        s2_i32,
  output logic        s2_ferr
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  r_state;
  logic [63:0] r_pc;
  logic        r_s2_valid;
  logic [63:0] r_s2_pc;
  logic [63:0] r_s2_npc;
  logic [31:0] r_s2_instr;
  logic        r_s2_i32;
  logic        r_s2_ferr;

  logic        w_e_cf;
  logic        w_slot_free;
  logic        w_accept;
  logic [63:0] w_size;
  logic [63:0] w_pc_next;
  logic [63:0] w_cf_pc;
  logic [31:0] w_instr;
  logic        w_ferr;
  logic        w_unused_cf_bit0;

  assign w_e_cf      = cf_valid && cf_ack;
  assign w_slot_free = !r_s2_valid || s2_ready;
  // Reset gates accept so no bytes are consumed while the stage is being reset.
  assign w_accept    = (s1_i16bit || s1_i32bit) && w_slot_free && !w_e_cf &&
                       (r_state == ST_RUN) && !g_reset;

  // A 32-bit indication wins if fetch ever flags both, so only one eat fires.
  assign s1_eat_4 = w_accept && s1_i32bit;
  assign s1_eat_2 = w_accept && !s1_i32bit;

  assign w_size    = s1_i32bit ? 64'd4 : 64'd2;
  assign w_pc_next = r_pc + w_size;
  assign w_cf_pc   = {cf_target[63:1], 1'b0};
  assign w_instr   = s1_i32bit ? s1_instr : {16'h0000, s1_instr[15:0]};
  assign w_ferr    = s1_ferr[0] || (s1_i32bit && s1_ferr[1]);

  // Target bit 0 is architecturally ignored; halfword alignment is forced.
  assign w_unused_cf_bit0 = cf_target[0];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state    <= ST_RUN;
      r_pc       <= PC_RESET_ADDRESS;
      r_s2_valid <= 1'b0;
      r_s2_pc    <= 64'd0;
      r_s2_npc   <= 64'd0;
      r_s2_instr <= 32'd0;
      r_s2_i32   <= 1'b0;
      r_s2_ferr  <= 1'b0;
    end else if (w_e_cf) begin
      r_state    <= ST_RUN;
      r_pc       <= w_cf_pc;
      r_s2_valid <= 1'b0;
    end else if (w_accept) begin
      r_pc       <= w_pc_next;
      r_s2_valid <= 1'b1;
      r_s2_pc    <= r_pc;
      r_s2_npc   <= w_pc_next;
      r_s2_instr <= w_instr;
      r_s2_i32   <= s1_i32bit;
      r_s2_ferr  <= w_ferr;
      if (w_ferr) begin
        r_state <= ST_HALT;
      end
    end else if (s2_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign s2_valid = r_s2_valid;
  assign s2_pc    = r_s2_pc;
  assign s2_npc   = r_s2_npc;
  assign s2_instr = r_s2_instr;
  assign s2_i32   = r_s2_i32;
  assign s2_ferr  = r_s2_ferr;

endmodule

// File: tb/tb_core_pipe_decode_issue.sv
// Directed bench for core_pipe_decode_issue: a per-cycle vector table with
// hand-computed expectations, followed by a few hand-written corner sequences.
module tb_core_pipe_decode_issue;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        cf_valid, cf_ack;
  logic [63:0] cf_target;
  logic        s1_i16bit, s1_i32bit;
  logic [31:0] s1_instr;
  logic [1:0]  s1_ferr;
  logic        s1_eat_2, s1_eat_4;
  logic        s2_valid, s2_ready;
  logic [63:0] s2_pc, s2_npc;
  logic [31:0] s2_instr;
  logic        s2_i32, s2_ferr;

  int n_checks = 0;
  int n_pass   = 0;

  core_pipe_decode_issue #(.PC_RESET_ADDRESS(64'h10000000)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cf_valid(cf_valid), .cf_ack(cf_ack), .cf_target(cf_target),
    .s1_i16bit(s1_i16bit), .s1_i32bit(s1_i32bit), .s1_instr(s1_instr), .s1_ferr(s1_ferr),
    .s1_eat_2(s1_eat_2), .s1_eat_4(s1_eat_4),
    .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_pc(s2_pc), .s2_npc(s2_npc),
    .s2_instr(s2_instr), .s2_i32(s2_i32), .s2_ferr(s2_ferr)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic        rst;
    logic        i16, i32;
    logic [31:0] instr;
    logic [1:0]  ferr;
    logic        ready, cfv, cfa;
    logic [63:0] tgt;
    logic        e2, e4;        // expected eats during the cycle
    logic        v;             // expected s2_valid after the edge
    logic        chk;           // compare s2 payload after the edge
    logic [63:0] pc, npc;
    logic [31:0] ins;
    logic        i32o, fe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic i16, input logic i32, input logic [31:0] instr,
    input logic [1:0] ferr, input logic ready, input logic cfv, input logic cfa,
    input logic [63:0] tgt, input logic e2, input logic e4, input logic v,
    input logic chk, input logic [63:0] pc, input logic [63:0] npc,
    input logic [31:0] ins, input logic i32o, input logic fe);
    vec_t t;
    t.rst = rst; t.i16 = i16; t.i32 = i32; t.instr = instr; t.ferr = ferr;
    t.ready = ready; t.cfv = cfv; t.cfa = cfa; t.tgt = tgt;
    t.e2 = e2; t.e4 = e4; t.v = v; t.chk = chk; t.pc = pc; t.npc = npc;
    t.ins = ins; t.i32o = i32o; t.fe = fe;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
  endtask

  task automatic drive(input logic rst, input logic i16, input logic i32,
                       input logic [31:0] instr, input logic [1:0] ferr,
                       input logic ready, input logic cfv, input logic cfa,
                       input logic [63:0] tgt);
    g_reset = rst; s1_i16bit = i16; s1_i32bit = i32; s1_instr = instr;
    s1_ferr = ferr; s2_ready = ready; cf_valid = cfv; cf_ack = cfa; cf_target = tgt;
  endtask

  task automatic check_eats(input int idx, input logic e2, input logic e4);
    #1;
    check("eat_2", idx, 64'(s1_eat_2), 64'(e2));
    check("eat_4", idx, 64'(s1_eat_4), 64'(e4));
  endtask

  task automatic check_s2(input int idx, input logic v, input logic chk,
                          input logic [63:0] pc, input logic [63:0] npc,
                          input logic [31:0] ins, input logic i32o, input logic fe);
    check("s2_valid", idx, 64'(s2_valid), 64'(v));
    if (chk) begin
      check("s2_pc", idx, s2_pc, pc);
      check("s2_npc", idx, s2_npc, npc);
      check("s2_instr", idx, 64'(s2_instr), 64'(ins));
      check("s2_i32", idx, 64'(s2_i32), 64'(i32o));
      check("s2_ferr", idx, 64'(s2_ferr), 64'(fe));
    end
  endtask

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    localparam logic [63:0] R = 64'h10000000;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();

    //        rst i16 i32 instr          ferr   rdy cfv cfa tgt                     e2 e4 v  chk pc                      npc                     ins            i32 fe
    // reset with an instruction present: no eats, s2 cleared
    vecs.push_back(mk(1, 0, 1, 32'h00000013, 2'b00, 1, 0, 0, 64'h0,                 0, 0, 0, 1, 64'h0,                  64'h0,                  32'h0,         0, 0));
    // first 32-bit issue after reset
    vecs.push_back(mk(0, 0, 1, 32'h00000013, 2'b00, 1, 0, 0, 64'h0,                 0, 1, 1, 1, R,                      R + 4,                  32'h00000013,  1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h00004501, 2'b00, 1, 0, 0, 64'h0,                 0, 0, 0, 1, 64'h0,                  64'h0,                  32'h0,         0, 0));
    // 16-bit then 32-bit back-to-back; upper half of a 16-bit fetch is zeroed
    vecs.push_back(mk(0, 1, 0, 32'hDEAD4501, 2'b00, 1, 0, 0, 64'h0,                 1, 0, 1, 1, R,                      R + 2,                  32'h00004501,  0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h00A00093, 2'b00, 1, 0, 0, 64'h0,                 0, 1, 1, 1, R + 2,                  R + 6,                  32'h00A00093,  1, 0));
    // three stall cycles with the next instruction waiting
    vecs.push_back(mk(0, 1, 0, 32'h00004082, 2'b00, 0, 0, 0, 64'h0,                 0, 0, 1, 1, R + 2,                  R + 6,                  32'h00A00093,  1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00004082, 2'b00, 0, 0, 0, 64'h0,                 0, 0, 1, 1, R + 2,                  R + 6,                  32'h00A00093,  1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00004082, 2'b00, 0, 0, 0, 64'h0,                 0, 0, 1, 1, R + 2,                  R + 6,                  32'h00A00093,  1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00004082, 2'b00, 1, 0, 0, 64'h0,                 1, 0, 1, 1, R + 6,                  R + 8,                  32'h00004082,  0, 0));
    // cf_valid without cf_ack is ignored
    vecs.push_back(mk(0, 0, 1, 32'h12345678, 2'b00, 1, 1, 0, 64'h80000003,          0, 1, 1, 1, R + 8,                  R + 12,                 32'h12345678,  1, 0));
    // stall, then flush during stall with an instruction available
    vecs.push_back(mk(0, 1, 0, 32'h00001111, 2'b00, 0, 0, 0, 64'h0,                 0, 0, 1, 1, R + 8,                  R + 12,                 32'h12345678,  1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00001111, 2'b00, 0, 1, 1, 64'h80000003,          0, 0, 0, 0, 64'h0,                  64'h0,                  32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h00000013, 2'b00, 1, 0, 0, 64'h0,                 0, 1, 1, 1, 64'h80000002,           64'h80000006,           32'h00000013,  1, 0));
    // nothing available: no eat, s2 drains, PC holds
    vecs.push_back(mk(0, 0, 0, 32'h00000000, 2'b00, 1, 0, 0, 64'h0,                 0, 0, 0, 0, 64'h0,                  64'h0,                  32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00000001, 2'b00, 1, 0, 0, 64'h0,                 1, 0, 1, 1, 64'h80000006,           64'h80000008,           32'h00000001,  0, 0));
    // fetch error on upper half of a 32-bit instruction -> HALT
    vecs.push_back(mk(0, 0, 1, 32'hCAFEBABE, 2'b10, 1, 0, 0, 64'h0,                 0, 1, 1, 1, 64'h80000008,           64'h8000000C,           32'hCAFEBABE,  1, 1));
    vecs.push_back(mk(0, 1, 0, 32'h00004501, 2'b00, 1, 0, 0, 64'h0,                 0, 0, 0, 0, 64'h0,                  64'h0,                  32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00004501, 2'b00, 1, 0, 0, 64'h0,                 0, 0, 0, 0, 64'h0,                  64'h0,                  32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00004501, 2'b00, 1, 1, 1, 64'h200,               0, 0, 0, 0, 64'h0,                  64'h0,                  32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00004501, 2'b00, 1, 0, 0, 64'h0,                 1, 0, 1, 1, 64'h200,                64'h202,                32'h00004501,  0, 0));
    // upper-half error does not apply to a 16-bit instruction; lower-half does
    vecs.push_back(mk(0, 1, 0, 32'h00004501, 2'b10, 1, 0, 0, 64'h0,                 1, 0, 1, 1, 64'h202,                64'h204,                32'h00004501,  0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00004501, 2'b01, 1, 0, 0, 64'h0,                 1, 0, 1, 1, 64'h204,                64'h206,                32'h00004501,  0, 1));
    // odd target out of HALT, then 32-bit accept across the 2^64 wrap
    vecs.push_back(mk(0, 1, 0, 32'h00004501, 2'b00, 1, 1, 1, 64'hFFFFFFFFFFFFFFFF,  0, 0, 0, 0, 64'h0,                  64'h0,                  32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h00000013, 2'b00, 1, 0, 0, 64'h0,                 0, 1, 1, 1, 64'hFFFFFFFFFFFFFFFE,   64'h2,                  32'h00000013,  1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00004501, 2'b00, 1, 0, 0, 64'h0,                 1, 0, 1, 1, 64'h2,                  64'h4,                  32'h00004501,  0, 0));
    // reset mid-stall overrides a simultaneous flush
    vecs.push_back(mk(0, 1, 0, 32'h00004501, 2'b00, 0, 0, 0, 64'h0,                 0, 0, 1, 1, 64'h2,                  64'h4,                  32'h00004501,  0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h00000013, 2'b00, 0, 1, 1, 64'h400,               0, 0, 0, 1, 64'h0,                  64'h0,                  32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h00000013, 2'b00, 1, 0, 0, 64'h0,                 0, 1, 1, 1, R,                      R + 4,                  32'h00000013,  1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].i16, vecs[i].i32, vecs[i].instr, vecs[i].ferr,
            vecs[i].ready, vecs[i].cfv, vecs[i].cfa, vecs[i].tgt);
      check_eats(i, vecs[i].e2, vecs[i].e4);
      tick();
      check_s2(i, vecs[i].v, vecs[i].chk, vecs[i].pc, vecs[i].npc,
               vecs[i].ins, vecs[i].i32o, vecs[i].fe);
    end

    // Flush beats accept even when the slot is free.
    drive(1'b0, 1'b1, 1'b0, 32'h00004501, 2'b00, 1'b1, 1'b1, 1'b1, 64'h1000);
    check_eats(100, 1'b0, 1'b0);
    tick();
    check_s2(100, 1'b0, 1'b0, 64'h0, 64'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h00000013, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0);
    check_eats(101, 1'b0, 1'b1);
    tick();
    check_s2(101, 1'b1, 1'b1, 64'h1000, 64'h1004, 32'h00000013, 1'b1, 1'b0);

    // Reset taken while halted returns to RUN at the reset PC.
    drive(1'b0, 1'b0, 1'b1, 32'h00000013, 2'b01, 1'b1, 1'b0, 1'b0, 64'h0);
    check_eats(102, 1'b0, 1'b1);
    tick();
    check_s2(102, 1'b1, 1'b1, 64'h1004, 64'h1008, 32'h00000013, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h00004501, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0);
    check_eats(103, 1'b0, 1'b0);
    tick();
    check_s2(103, 1'b0, 1'b1, 64'h0, 64'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h00004501, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0);
    check_eats(104, 1'b1, 1'b0);
    tick();
    check_s2(104, 1'b1, 1'b1, R, R + 2, 32'h00004501, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
